// File: rtl/definitions_pkg.sv
// Shared types for the load/store path: access sizes, unit state encoding
// and the alignment rule used to decide whether an access must be split.
package definitions;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_unit_state_t;

  // HALF needs addr[0]=0, WORD needs addr[1:0]=0; BYTE is always aligned.
  function automatic logic is_misaligned(input mem_access_size_t size,
                                         input logic [1:0] addr_lsb);
    return ((size == HALF) && addr_lsb[0]) ||
           ((size == WORD) && (addr_lsb != 2'b00));
  endfunction

  // Index of the final byte when an access is split into byte accesses.
  function automatic logic [1:0] last_byte_idx(input mem_access_size_t size);
    return (size == WORD) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Single-port memory interface: combinational read, write committed on the
// clock edge ending the cycle in which wr_enable is high.
interface mem_if;
  import definitions::*;

  logic [31:0]      rd_addr;
  mem_access_size_t rd_size;
  logic [31:0]      rd_data;
  logic             wr_enable;
  logic [31:0]      wr_addr;
  mem_access_size_t wr_size;
  logic [31:0]      wr_data;

  modport slave (
    output rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data,
    input  rd_data
  );

  modport memory (
    input  rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data,
    output rd_data
  );
endinterface

// File: rtl/mem_load_extend.sv
// Zero/sign extension of raw load data according to access size.
module mem_load_extend
  import definitions::*;
(
  input  mem_access_size_t size_i,
  input  logic             signed_i,
  input  logic [31:0]      raw_i,
  output logic [31:0]      data_o
);

  // Replicate bit 7 (BYTE) or bit 15 (HALF) upward for signed loads.
  always_comb begin
    data_o = raw_i;
    case (size_i)
      BYTE:    data_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      HALF:    data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: accepts one request at a time, issues the memory
// access (splitting misaligned HALF/WORD into byte accesses when enabled),
// extends load data and returns a response for every request.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory access in progress (1 cycle aligned, 2/4 cycles split)
// RESP   | response held until consumer takes it
module mem_access_unit
  import definitions::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  mem_access_size_t req_size_i,
  input  logic             req_signed_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_error_o,
  mem_if.slave             memif
);

  mem_unit_state_t  state_q, state_d;
  logic             write_q, signed_q, mis_q, err_q;
  mem_access_size_t size_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [1:0]       cnt_q;

  logic             req_mis;
  logic             access_last;
  logic [4:0]       byte_shift;
  logic [31:0]      access_addr;
  logic [31:0]      assembled;
  logic [31:0]      ext_data;

  assign req_mis     = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign access_last = !mis_q || (cnt_q == last_byte_idx(size_q));
  assign byte_shift  = {cnt_q, 3'b000};
  assign access_addr = addr_q + {30'd0, (mis_q ? cnt_q : 2'd0)};

  // Merge the byte just read into the partial result; aligned loads take it all.
  always_comb begin
    assembled = rdata_q;
    if (mis_q) assembled[byte_shift +: 8] = memif.rd_data[7:0];
    else       assembled = memif.rd_data;
  end

  mem_load_extend u_load_extend (
    .size_i   (size_q),
    .signed_i (signed_q),
    .raw_i    (assembled),
    .data_o   (ext_data)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i)
                 state_d = (!SPLIT_MISALIGNED && req_mis) ? RESP : ACCESS;
      ACCESS:  if (access_last) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, byte counter and load-data assembly.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          write_q  <= req_write_i;
          signed_q <= req_signed_i;
          size_q   <= req_size_i;
          addr_q   <= req_addr_i;
          wdata_q  <= req_wdata_i;
          mis_q    <= req_mis;
          err_q    <= !SPLIT_MISALIGNED && req_mis;
          rdata_q  <= '0;
          cnt_q    <= '0;
        end
        ACCESS: begin
          if (!write_q) rdata_q <= access_last ? ext_data : assembled;
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Handshake, response and memory port drive.
  always_comb begin
    req_ready_o     = (state_q == IDLE);
    rsp_valid_o     = (state_q == RESP);
    rsp_rdata_o     = (state_q == RESP) ? rdata_q : '0;
    rsp_error_o     = (state_q == RESP) && err_q;
    memif.wr_enable = 1'b0;
    memif.rd_addr   = addr_q;
    memif.wr_addr   = addr_q;
    memif.rd_size   = BYTE;
    memif.wr_size   = BYTE;
    memif.wr_data   = '0;
    if (state_q == ACCESS) begin
      memif.rd_addr = access_addr;
      memif.wr_addr = access_addr;
      memif.rd_size = mis_q ? BYTE : size_q;
      memif.wr_size = mis_q ? BYTE : size_q;
      if (write_q) begin
        memif.wr_enable = 1'b1;
        memif.wr_data   = mis_q ? {24'd0, wdata_q[byte_shift +: 8]} : wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed memory model and
// scoreboards for expected responses and expected memory writes.
module tb_mem_access_unit;
  import definitions::*;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; mem_access_size_t size; } wr_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             reset_ni;
  logic             req_valid_i, r_req_valid;
  logic             req_write_i, req_signed_i;
  mem_access_size_t req_size_i;
  logic [31:0]      req_addr_i, req_wdata_i;
  logic             rsp_ready_i;
  logic             req_ready_o, rsp_valid_o, rsp_error_o;
  logic [31:0]      rsp_rdata_o;
  logic             r_req_ready, r_rsp_valid, r_rsp_error;
  logic [31:0]      r_rsp_rdata;

  mem_if mif ();
  mem_if mif_r ();

  mem_access_unit dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_size_i(req_size_i),
    .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o), .memif(mif)
  );

  mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut_r (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(r_req_valid), .req_ready_o(r_req_ready),
    .req_write_i(req_write_i), .req_size_i(req_size_i),
    .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(r_rsp_valid),
    .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(r_rsp_rdata),
    .rsp_error_o(r_rsp_error), .memif(mif_r)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int mem_ver  = 0;
  int pre_ver  = 0;
  logic r_wr_seen = 1'b0;

  logic [7:0] mem [logic [31:0]];
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a, input mem_access_size_t s);
    logic [31:0] r;
    int n;
    r = '0;
    n = (s == WORD) ? 4 : (s == HALF) ? 2 : 1;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rd_byte(a + i);
    return r;
  endfunction

  // Memory model: combinational read, write on the rising edge.
  always @(mif.rd_addr or mif.rd_size or mem_ver or pre_ver)
    mif.rd_data = mem_read(mif.rd_addr, mif.rd_size);

  always @(posedge clk_i) begin
    if (mif.wr_enable) begin
      mem[mif.wr_addr] = mif.wr_data[7:0];
      if (mif.wr_size != BYTE) mem[mif.wr_addr + 32'd1] = mif.wr_data[15:8];
      if (mif.wr_size == WORD) begin
        mem[mif.wr_addr + 32'd2] = mif.wr_data[23:16];
        mem[mif.wr_addr + 32'd3] = mif.wr_data[31:24];
      end
      mem_ver = mem_ver + 1;
    end
  end

  assign mif_r.rd_data = 32'h0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) if (mif_r.wr_enable === 1'b1) r_wr_seen = 1'b1;

  // Write scoreboard.
  always @(negedge clk_i) begin
    if (mif.wr_enable === 1'b1) begin
      check("write_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_addr", mif.wr_addr, w.addr);
        check("wr_data", mif.wr_data, w.data);
        check("wr_size", 32'(mif.wr_size), 32'(w.size));
      end
    end
  end

  // Response scoreboard.
  always @(negedge clk_i) begin
    if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
      check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, r.rdata);
        check("rsp_error", 32'(rsp_error_o), 32'(r.err));
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    mem[a] = v;
    pre_ver++;
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input mem_access_size_t s);
    wr_t w;
    w.addr = a; w.data = d; w.size = s;
    wr_q.push_back(w);
  endtask

  task automatic set_req(input logic w, input mem_access_size_t s, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
    req_write_i = w; req_size_i = s; req_signed_i = sg;
    req_addr_i = a; req_wdata_i = d;
  endtask

  // Drive a request for one edge; returns 1 time unit into cycle 1.
  task automatic issue(input logic w, input mem_access_size_t s, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    set_req(w, s, sg, a, d);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    t0 = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int g;
    g = 0;
    @(negedge clk_i);
    while (rsp_valid_o !== 1'b1 && g < 40) begin
      @(negedge clk_i);
      g++;
    end
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    check({tag, "_latency"}, 32'(cyc - t0 + 1), 32'(exp_lat));
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0;
    req_valid_i = 1'b0; r_req_valid = 1'b0; rsp_ready_i = 1'b1;
    set_req(1'b0, BYTE, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_req_ready", 32'(req_ready_o), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rsp_rdata", rsp_rdata_o, 32'h0);
    check("reset_rsp_error", 32'(rsp_error_o), 32'd0);
    check("reset_wr_enable", 32'(mif.wr_enable), 32'd0);
    check("reset_wr_addr", mif.wr_addr, 32'h0);
    check("reset_rd_addr", mif.rd_addr, 32'h0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    // Aligned word load.
    preload(32'h100, 8'hEF); preload(32'h101, 8'hBE);
    preload(32'h102, 8'hAD); preload(32'h103, 8'hDE);
    push_rsp(32'hDEADBEEF, 1'b0);
    issue(1'b0, WORD, 1'b0, 32'h100, 32'h0);
    @(negedge clk_i);
    check("wl_rd_addr", mif.rd_addr, 32'h100);
    check("wl_rd_size", 32'(mif.rd_size), 32'(WORD));
    check("wl_no_write", 32'(mif.wr_enable), 32'd0);
    wait_rsp("word_load", 2);

    // Extension.
    preload(32'h102, 8'h34); preload(32'h103, 8'h80);
    push_rsp(32'hFFFFFF80, 1'b0);
    issue(1'b0, BYTE, 1'b1, 32'h103, 32'h0);
    wait_rsp("byte_signed", 2);
    push_rsp(32'h00000080, 1'b0);
    issue(1'b0, BYTE, 1'b0, 32'h103, 32'h0);
    wait_rsp("byte_unsigned", 2);
    push_rsp(32'hFFFF8034, 1'b0);
    issue(1'b0, HALF, 1'b1, 32'h102, 32'h0);
    wait_rsp("half_signed", 2);

    // Misaligned word store, then reads back.
    push_wr(32'h101, 32'h44, BYTE); push_wr(32'h102, 32'h33, BYTE);
    push_wr(32'h103, 32'h22, BYTE); push_wr(32'h104, 32'h11, BYTE);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, WORD, 1'b0, 32'h101, 32'h11223344);
    wait_rsp("mis_store", 5);
    push_rsp(32'h00000011, 1'b0);
    issue(1'b0, WORD, 1'b0, 32'h104, 32'h0);
    wait_rsp("load_104", 2);
    push_rsp(32'h11223344, 1'b0);
    issue(1'b0, WORD, 1'b1, 32'h101, 32'h0);
    wait_rsp("mis_load", 5);

    // Aligned half store and signed read back.
    push_wr(32'h200, 32'h1234BEEF, HALF);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, HALF, 1'b0, 32'h200, 32'h1234BEEF);
    wait_rsp("half_store", 2);
    push_rsp(32'hFFFFBEEF, 1'b0);
    issue(1'b0, HALF, 1'b1, 32'h200, 32'h0);
    wait_rsp("half_load", 2);

    // Address wrap-around.
    preload(32'hFFFFFFFF, 8'hAA); preload(32'h0, 8'hBB);
    push_rsp(32'h0000BBAA, 1'b0);
    issue(1'b0, HALF, 1'b0, 32'hFFFFFFFF, 32'h0);
    @(negedge clk_i);
    check("wrap_addr0", mif.rd_addr, 32'hFFFFFFFF);
    check("wrap_size0", 32'(mif.rd_size), 32'(BYTE));
    @(negedge clk_i);
    check("wrap_addr1", mif.rd_addr, 32'h00000000);
    wait_rsp("wrap", 3);

    // Rejection with splitting disabled.
    set_req(1'b1, WORD, 1'b0, 32'h202, 32'hCAFEF00D);
    r_req_valid = 1'b1;
    @(posedge clk_i); #1;
    r_req_valid = 1'b0;
    @(negedge clk_i);
    check("rej_valid", 32'(r_rsp_valid), 32'd1);
    check("rej_error", 32'(r_rsp_error), 32'd1);
    check("rej_rdata", r_rsp_rdata, 32'h0);
    @(negedge clk_i);
    check("rej_back_idle", 32'(r_req_ready), 32'd1);
    check("rej_no_write", 32'(r_wr_seen), 32'd0);
    @(posedge clk_i); #1;

    // Backpressure with a second request waiting.
    rsp_ready_i = 1'b0;
    push_rsp(32'h000000EF, 1'b0);
    push_rsp(32'h0000BEEF, 1'b0);
    set_req(1'b0, BYTE, 1'b0, 32'h200, 32'h0);
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    t0 = cyc;
    set_req(1'b0, HALF, 1'b0, 32'h200, 32'h0);
    @(negedge clk_i);
    check("bp_busy_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("bp_valid", 32'(rsp_valid_o), 32'd1);
    check("bp_latency", 32'(cyc - t0 + 1), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_hold_rdata", rsp_rdata_o, 32'h000000EF);
      check("bp_hold_ready", 32'(req_ready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("bp_idle_ready", 32'(req_ready_o), 32'd1);
    check("bp_idle_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i); #1;
    t0 = cyc;
    req_valid_i = 1'b0;
    wait_rsp("bp_second", 2);

    // Reset in the middle of a misaligned word store.
    push_wr(32'h301, 32'hD4, BYTE); push_wr(32'h302, 32'hC3, BYTE);
    issue(1'b1, WORD, 1'b0, 32'h301, 32'hA1B2C3D4);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check("mid_rst_rsp_error", 32'(rsp_error_o), 32'd0);
    check("mid_rst_wr_enable", 32'(mif.wr_enable), 32'd0);
    check("mid_rst_wr_addr", mif.wr_addr, 32'h0);
    check("mid_rst_rd_addr", mif.rd_addr, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("mid_rst_byte0", 32'(rd_byte(32'h301)), 32'hD4);
    check("mid_rst_byte1", 32'(rd_byte(32'h302)), 32'hC3);
    check("mid_rst_byte2", 32'(rd_byte(32'h303)), 32'h00);
    check("mid_rst_byte3", 32'(rd_byte(32'h304)), 32'h00);
    check("mid_rst_no_rsp", 32'(rsp_valid_o), 32'd0);

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end that sits directly upstream of the memory model and drives its `mem_if` port. It accepts one load or store request at a time from the pipeline over a valid/ready handshake and issues the matching memory access. Misaligned half/word accesses are split into sequential byte accesses. Load results are zero- or sign-extended, and a completion response is returned for every request.

## Interface
- `SPLIT_MISALIGNED`, default 1: 1 splits misaligned accesses into byte accesses; 0 rejects them with `rsp_error_o` and performs no access.
- `clk_i` input 1: clock; all state changes on the rising edge.
- `reset_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: request present.
- `req_ready_o` output 1: unit can accept a request; high only in IDLE.
- `req_write_i` input 1: 1 = store, 0 = load.
- `req_size_i` input `mem_access_size_t`: BYTE, HALF or WORD.
- `req_signed_i` input 1: sign-extend load result; ignored for stores.
- `req_addr_i` input 32: byte address.
- `req_wdata_i` input 32: store data, right-aligned.
- `rsp_valid_o` output 1: response present.
- `rsp_ready_i` input 1: consumer takes the response.
- `rsp_rdata_o` output 32: extended load data; 0 for stores and errors.
- `rsp_error_o` output 1: misaligned request rejected (only possible when `SPLIT_MISALIGNED`=0).
- `memif` `mem_if.slave`: drives `rd_addr`, `rd_size`, `wr_enable`, `wr_addr`, `wr_size`, `wr_data`; samples `rd_data`.
  - Read data is combinational in the same cycle.
  - A write commits on the clock edge that ends the cycle in which `wr_enable` is high.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch write, size, signed, address and data, then go to ACCESS.
  - If `SPLIT_MISALIGNED`=0 and the request is misaligned, latch the error and go directly to RESP.
- **Misalignment** is defined as HALF with `addr[0]`≠0, or WORD with `addr[1:0]`≠0.
- **ACCESS, aligned request**
  - One cycle.
  - `rd_addr`/`wr_addr` = latched address; `rd_size`/`wr_size` = latched size.
  - For stores, `wr_enable`=1 and `wr_data` = latched data.
  - For loads, capture `rd_data` at the end of the cycle.
- **ACCESS, misaligned request**
  - N cycles, where N = 2 (HALF) or 4 (WORD). A 2-bit byte counter k runs from 0 to N-1.
  - Size is BYTE. Address = base + k, computed modulo 2^32, so it wraps from 0xFFFFFFFF to 0x00000000.
  - Store: `wr_data[7:0]` = `wdata[8k+7:8k]`; upper bits are 0.
  - Load: `rd_data[7:0]` is written into `rdata[8k+7:8k]` (little-endian).
  - After the last byte, go to RESP.
- **RESP**
  - `rsp_valid_o`=1. `rsp_rdata_o` and `rsp_error_o` hold steady.
  - When `rsp_ready_i`=1, go to IDLE.
- **Extension** is applied to the assembled value when entering RESP.
  - BYTE uses bit 7 and HALF uses bit 15, replicated upward if `req_signed_i` was set; otherwise zero-extended.
  - WORD is unchanged.
- **Memory port outside ACCESS:** `wr_enable`=0, `rd_addr` = latched address, `rd_size` = BYTE, `wr_data`=0.
- `req_valid_i` while not in IDLE is ignored; the request is not accepted.

## Timing
- **Reset values:** state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_error_o`=0, `wr_enable`=0, `wr_addr`=0, `rd_addr`=0, counter=0.
- **Latency:** accepted at edge E0.
  - Aligned: ACCESS in cycle 1, `rsp_valid_o` from cycle 2.
  - Misaligned HALF: `rsp_valid_o` from cycle 3. Misaligned WORD: from cycle 5.
  - Rejected: `rsp_valid_o` from cycle 1.
- **Throughput:** with `rsp_ready_i` held high, an aligned access completes every 3 cycles (IDLE, ACCESS, RESP). There is no accept in the same cycle as a response handshake.
- **Backpressure:** while `rsp_ready_i`=0, RESP holds indefinitely with outputs stable and `req_ready_o`=0.
- **Reset mid-operation:** returns to IDLE immediately. Bytes already written stay written, no further writes occur, and no response is produced.

## Structure
- Add `mem_unit_state_t` (IDLE/ACCESS/RESP) to the `definitions` package. The unit reuses `mem_access_size_t` from there.
- One combinational sub-module, `mem_load_extend` (size, signed flag, 32-bit raw data in; 32-bit extended data out), shared with later units.

## Test plan
- **Aligned word load:** memory[0x100]=0xDEADBEEF, load WORD at 0x100 -> one ACCESS cycle, `rsp_rdata_o`=0xDEADBEEF in cycle 2, `rsp_error_o`=0.
- **Byte extension:** memory[0x103]=0x80.
  - Signed BYTE load -> 0xFFFFFF80.
  - Unsigned BYTE load -> 0x00000080.
  - Signed HALF load at 0x102 with bytes 0x34/0x80 -> 0xFFFF8034.
- **Misaligned word store:** store 0x11223344 WORD at 0x101 -> four byte writes 0x44@0x101, 0x33@0x102, 0x22@0x103, 0x11@0x104 in cycles 1-4; response in cycle 5; a follow-up aligned load of 0x104 returns its low byte 0x11.
- **Wrap-around:** memory[0xFFFFFFFF]=0xAA, memory[0x0]=0xBB, unsigned HALF load at 0xFFFFFFFF -> `rd_addr` sequence 0xFFFFFFFF, 0x00000000; result 0x0000BBAA.
- **Rejection:** `SPLIT_MISALIGNED`=0, WORD store at 0x202 -> `wr_enable` never high, `rsp_error_o`=1 with `rsp_rdata_o`=0 in cycle 1.
- **Backpressure and reset:**
  - Hold `rsp_ready_i`=0 for 3 cycles with `req_valid_i` asserted -> response stable and `req_ready_o`=0; one handshake, then the next request is accepted.
  - Assert `reset_ni` low after byte 1 of a misaligned WORD store -> only bytes 0-1 are written, all outputs return to their reset values immediately.
